// File: rtl/led_pwm_pkg.sv
// ============================================================================
// Module      : led_pwm_pkg
// Description : Shared widths, limits and level-step helper for the LED fader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pwm_pkg;

  localparam int LEVEL_W = 8;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 8'hFF;
  localparam int NCH_MAX = 8;
  localparam int ADDR_W = $clog2(NCH_MAX);

  typedef logic [LEVEL_W-1:0] chan_level_t;

  // One unit toward the target, saturating at both ends of the range.
  function automatic chan_level_t step_toward(chan_level_t lvl, chan_level_t tgt);
    chan_level_t res;
    res = lvl;
    if ((lvl < tgt) && (lvl != LEVEL_MAX)) begin
      res = lvl + LEVEL_W'(1);
    end else if ((lvl > tgt) && (lvl != '0)) begin
      res = lvl - LEVEL_W'(1);
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_pwm_fader_if.sv
// ============================================================================
// Module      : led_pwm_fader_if
// Description : Valid/ready write port carrying a channel index and target.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_pwm_fader_if;
  import led_pwm_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  chan_level_t       wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

`default_nettype wire

// File: rtl/led_pwm_channel.sv
// ============================================================================
// Module      : led_pwm_channel
// Description : One LED channel: target register, fading level, PWM compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pwm_channel
  import led_pwm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  chan_level_t wr_data_i,
  input  logic        wrap_i,
  input  chan_level_t pwm_cnt_i,
  output logic        led_o,
  output logic        mismatch_o
);

  chan_level_t target_q, target_d;
  chan_level_t level_q, level_d;
  logic        led_q, led_d;

  // The step reads target_q, so a write landing on a wrap waits one period.
  always_comb begin
    target_d = we_i ? wr_data_i : target_q;
    level_d  = wrap_i ? step_toward(level_q, target_q) : level_q;
    led_d    = (pwm_cnt_i < level_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= '0;
      level_q  <= '0;
      led_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      level_q  <= level_d;
      led_q    <= led_d;
    end
  end

  assign led_o      = led_q;
  assign mismatch_o = (level_q != target_q);

endmodule

`default_nettype wire

// File: rtl/led_pwm_fader.sv
// ============================================================================
// Module      : led_pwm_fader
// Description : Per-LED brightness/fade engine with shared prescaler and PWM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pwm_fader
  import led_pwm_pkg::*;
#(
  parameter int NCH      = 8,
  parameter int PRESCALE = 16
) (
  input  logic           clk,
  input  logic           rst,
  led_pwm_fader_if.slave wr,
  output logic [NCH-1:0] led,
  output logic           period_strobe,
  output logic           busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_cnt_q, presc_cnt_d;
  chan_level_t   pwm_cnt_q, pwm_cnt_d;
  logic          wr_ready_q;
  logic          period_strobe_q;
  logic          busy_q, busy_d;
  logic          tick;
  logic          wrap;
  logic          wr_fire;
  logic [NCH-1:0] chan_we;
  logic [NCH-1:0] mismatch;

  assign tick    = (presc_cnt_q == PRESC_LAST);
  assign wrap    = tick && (pwm_cnt_q == LEVEL_MAX);
  assign wr_fire = wr.wr_valid && wr_ready_q;

  always_comb begin
    presc_cnt_d = tick ? '0 : presc_cnt_q + PW'(1);
    pwm_cnt_d   = tick ? pwm_cnt_q + LEVEL_W'(1) : pwm_cnt_q;
    busy_d      = |mismatch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_q     <= '0;
      pwm_cnt_q       <= '0;
      wr_ready_q      <= 1'b0;
      period_strobe_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      presc_cnt_q     <= presc_cnt_d;
      pwm_cnt_q       <= pwm_cnt_d;
      wr_ready_q      <= 1'b1;
      period_strobe_q <= wrap;
      busy_q          <= busy_d;
    end
  end

  // Addresses at or above NCH match no channel, so such writes are dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign chan_we[i] = wr_fire && (wr.wr_addr == ADDR_W'(i));

    led_pwm_channel u_chan (
      .clk        (clk),
      .rst        (rst),
      .we_i       (chan_we[i]),
      .wr_data_i  (wr.wr_data),
      .wrap_i     (wrap),
      .pwm_cnt_i  (pwm_cnt_q),
      .led_o      (led[i]),
      .mismatch_o (mismatch[i])
    );
  end

  assign wr.wr_ready    = wr_ready_q;
  assign period_strobe  = period_strobe_q;
  assign busy           = busy_q;

endmodule

`default_nettype wire

// File: doc/led_pwm_fader.md
# led_pwm_fader

Per-LED brightness and fade engine for the SoC LED bank. It sits between the SoC's LED output and the board's output IO buffers. It takes per-channel brightness targets through a simple write port, ramps each channel's level toward its target, and produces PWM-modulated active-high LED drive. The IO wrapper inverts that drive for the active-low board LEDs.

## Interface

Parameters:
- `NCH`, default 8: number of LED channels; legal range 1..8.
- `PRESCALE`, default 16: clock cycles per PWM tick; must be ≥1.

Ports:
- `clk`, input, 1 bit: the single clock; all logic is synchronous to it.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `wr_valid`, input, 1 bit: write request.
- `wr_ready`, output, 1 bit: write accept. A write transfers on any cycle where `wr_valid` and `wr_ready` are both high.
- `wr_addr`, input, 3 bits: channel index.
- `wr_data`, input, 8 bits: target brightness, 0..255.
- `led`, output, `NCH` bits: PWM drive, active-high.
- `period_strobe`, output, 1 bit: one-cycle pulse at each PWM period wrap.
- `busy`, output, 1 bit: high while any channel level differs from its target.

## Operation

Prescaler:
- `presc_cnt` counts 0..`PRESCALE`-1 and then wraps.
- `tick` is asserted when `presc_cnt` equals `PRESCALE`-1.
- With `PRESCALE`=1, `tick` is high every cycle.

PWM counter:
- `pwm_cnt` is 8 bits and increments on `tick`, wrapping from 255 to 0.
- `wrap` = `tick` AND `pwm_cnt`==255.
- One period is 256×`PRESCALE` clocks.

Per channel `i`, state is `target[i]` (8 bits) and `level[i]` (8 bits).

Writes:
- An accepted write with `wr_addr` < `NCH` loads `target[wr_addr]` from `wr_data`.
- An accepted write with `wr_addr` ≥ `NCH` is still accepted but has no effect.

Fade:
- On each `wrap`, every channel steps `level` by exactly 1 toward `target`: +1 if below, −1 if above, unchanged if equal.
- `level` never overshoots and never wraps past 0 or 255.

Compare:
- The registered `led[i]` equals (`pwm_cnt` < `level[i]`).
- Level 0 gives constant off. Level 255 gives on for 255 of 256 ticks. Full-on is not reachable by design.

Status outputs:
- `busy` is the registered OR over channels of (`level[i]` ≠ `target[i]`).
- `period_strobe` is `wrap` registered.

Simultaneous write and wrap on the same cycle:
- The level step uses the pre-write target.
- The new target first affects the level at the next `wrap`.

Re-targeting mid-fade:
- A new target is legal at any time.
- The fade reverses or continues from the current `level`, with no reset of `level`.

`wr_ready` is 0 while `rst` is high and 1 on every cycle thereafter; there is no backpressure in normal operation.

## Timing

Reset values (applied asynchronously on `rst` assertion):
- `presc_cnt`, `pwm_cnt`, all `target` and all `level` are 0.
- `led`, `period_strobe`, `busy` and `wr_ready` are 0.

After reset release:
- `wr_ready` rises at the first `clk` edge after `rst` deasserts.

Latencies:
- `led`: 1 cycle from the `pwm_cnt`/`level` state to the output.
- `period_strobe`: high for exactly 1 cycle, the cycle after `wrap`.
- `busy`: rises 1 cycle after an accepted write that creates a mismatch. It falls 1 cycle after the `wrap` that makes the last mismatched channel equal.
- New `level` values take effect on `led` from the next PWM period start: at `pwm_cnt`==0, visible 1 cycle later.

Reset asserted mid-fade:
- All state clears immediately and no partial write survives.

## Structure

Shared package `led_pwm_pkg`:
- `LEVEL_W`=8.
- `LEVEL_MAX`=8'hFF.
- `NCH_MAX`=8.
- `chan_level_t` typedef.

Sub-module `led_pwm_channel`, instantiated `NCH` times:
- Inputs: `clk`, `rst`, write enable, `wr_data`, `wrap`, `pwm_cnt`.
- Outputs: `led` bit and mismatch flag.

The top level holds the prescaler, PWM counter, address decode, and the `busy` OR-reduce.

## Test plan

All scenarios use `PRESCALE`=1 and `NCH`=8 unless stated.

1. Reset, then idle for 600 cycles → `led`=0, `busy`=0, `wr_ready`=1 from the first edge after `rst` falls, and `period_strobe` pulses every 256 cycles.
2. Write ch0=128 → `busy` rises the next cycle. `level[0]` reaches 128 after 128 wraps. After that, `led[0]` is high for 128 of every 256 cycles and `busy` is 0.
3. Fade ch3 to 255, then write 0 while `level` is 100 → the level reverses from 100 and reaches 0 after 100 further wraps, with no overshoot or wrap to 255.
4. Write ch1=5 on the same cycle as `wrap` → no step occurs at that wrap. `level[1]` is 1 after the next wrap.
5. Assert `rst` mid-fade at `level` 60 → all outputs are 0 immediately and no `led` pulses appear. After release, `level` starts again from 0.
6. Write `wr_addr`=7 with `NCH`=4 → the write is accepted (`wr_ready`=1), no channel changes, and `busy` stays 0.
